uart_digit_receiver: RTL and testbench
======================================

# uart_digit_receiver

Serial front end of the display path. Samples the UART line at 16× oversampling, deframes 8-bit even-parity characters, checks them, and packs four good digit characters into the four 4-bit codes that drive the 7-segment multiplexer. Its `bcd1`..`bcd4` outputs connect directly to the display driver's digit inputs.

## Interface
Parameters:
- `OVERSAMPLE_DIV`, default 27: Clk cycles per 1/16 bit. 50 MHz / (115200 × 16) ≈ 27.
- `RESET_CODE`, default 4'b1010: digit code driven on all four outputs after reset (dash).

Ports:
- `Clk` in 1: system clock, 50 MHz. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `RxD` in 1: asynchronous serial line, idle high.
- `Rx_DATA` out 8: last received byte. Loaded at every stop-bit sample, good or bad.
- `Rx_VALID` out 1: one-cycle pulse for a byte with no parity or framing error.
- `Rx_PERROR` out 1: one-cycle pulse when parity is wrong.
- `Rx_FERROR` out 1: one-cycle pulse when the stop bit is 0.
- `bcd1`, `bcd2`, `bcd3`, `bcd4` out 4 each: display digit codes. `bcd1` is the leftmost digit and the first received.
- `frame_done` out 1: one-cycle pulse when `bcd1`..`bcd4` are updated.

## Operation
- **Input synchronizer:** `RxD` passes through a 2-FF synchronizer. All logic uses the synchronized value `rx_s`.
- **Tick generator:** a counter 0..`OVERSAMPLE_DIV`-1 produces a one-cycle tick. It restarts at 0 when the FSM leaves IDLE, so sampling is phase-aligned to the start edge.
- **Frame format:** start bit (0), 8 data bits LSB first, even parity bit, stop bit (1).
- **FSM states:**
  - IDLE → START on a 1→0 transition of `rx_s`. IDLE is armed only after `rx_s` has been seen high.
  - START → at tick 8, sample `rx_s`. If it is 1 (glitch), return to IDLE with no flags. If it is 0, go to DATA with the tick count reset.
  - DATA → sample at every 16th tick (bit centre) into a right-shifting register. After 8 bits go to PARITY.
  - PARITY → sample at the 16th tick. Error if the XOR of the 8 data bits and the parity bit is 1.
  - STOP → sample at the 16th tick, then emit the flags and return to IDLE.
    - Stop sample 0: pulse `Rx_FERROR`, and IDLE stays disarmed until `rx_s` = 1 (break handling).
- **Flag rules:**
  - `Rx_VALID` = no parity error and no framing error.
  - `Rx_PERROR` and `Rx_FERROR` may pulse together.
  - `Rx_VALID` is never asserted together with either error flag.
- **Digit assembler** (acts only on flag cycles):
  - Valid byte with upper nibble 0: the lower nibble goes to slot[count], then count increments.
  - When count reaches 4, all four `bcd` outputs load together from slot[0..3] and count returns to 0.
  - Valid byte with upper nibble ≠ 0 (e.g. 0xFF as a resync): discard the byte, clear count, leave `bcd` unchanged.
  - Any error pulse: clear count, leave `bcd` unchanged.
  - The assembler does not check code range. Codes 0xA–0xF pass through to the display.
- **Reset:** applies on the cycle `reset` is sampled high, including mid-frame.
  - FSM → IDLE (disarmed until `rx_s` = 1); tick counter, count and slots cleared.
  - `Rx_DATA` = 0; `Rx_VALID`, `Rx_PERROR`, `Rx_FERROR`, `frame_done` = 0.
  - `bcd1`..`bcd4` = `RESET_CODE`.
- **Not supported:** no FIFO and no back-pressure. A consumer that misses a flag pulse loses that byte.

## Timing
- **Synchronizer latency:** 2 cycles from `RxD` to `rx_s`.
- **Bit period:** 16 × `OVERSAMPLE_DIV` cycles. The start sample falls 8 ticks after the detected edge; each later sample is 16 ticks after the previous one.
- **Flag timing:** `Rx_DATA` and the flag pulses become visible in the cycle after the stop-bit sample tick. Byte latency from the start edge is about 10.5 bit periods plus 3 cycles.
- **Digit update:** `bcd1`..`bcd4` and `frame_done` update in the cycle after the 4th `Rx_VALID`.
- **Back-to-back bytes:** a start edge arriving one cycle after the stop sample must be detected. Zero idle time between frames is supported.
- **Flag/reset collision:** if `reset` coincides with a flag-emit cycle, reset wins and no pulse or update occurs.

## Test plan
Run with `OVERSAMPLE_DIV` = 2 for speed. A bench UART model drives `RxD` at 32 cycles per bit.
- **Four good digits:** after reset, send 0x0A, 0x01, 0x09, 0x04 back-to-back, all with correct parity. Expect four `Rx_VALID` pulses, then one `frame_done`, then `bcd1`=1010, `bcd2`=0001, `bcd3`=1001, `bcd4`=0100.
- **Parity error mid-group:** send 0x03, 0x05, then 0x07 with wrong parity, then 0x01, 0x02, 0x03, 0x04. Expect one `Rx_PERROR` pulse (no `Rx_VALID` with it), `bcd` held at the old values until the last four bytes land, then 1, 2, 3, 4.
- **Framing error and break:** send 0x06 with stop = 0, then hold `RxD` low for 40 bit times, then release. Expect exactly one `Rx_FERROR`, no further start detection until release, and the next byte 0x02 received correctly.
- **Glitch rejection:** pulse `RxD` low for 6 cycles. Expect FSM back to IDLE with no flags and `Rx_DATA` unchanged.
- **Resync byte:** send 0x01, 0xFF, then 0x08, 0x08, 0x08, 0x08. Expect count cleared by 0xFF (`Rx_VALID` still pulses for it), then all four `bcd` outputs = 1000.
- **Reset mid-operation:** assert `reset` for 1 cycle during the DATA state of the 3rd byte. Expect all outputs at reset values (`bcd` = 1010), and a following complete 4-byte group displayed correctly.

Source files
------------

// File: rtl/uart_digit_receiver.sv
// UART receiver (16x oversampling, 8E1) feeding a four-digit display latch.
// Good digit bytes are gathered four at a time and presented on bcd1..bcd4.
module uart_digit_receiver #(
    parameter int          OVERSAMPLE_DIV = 27,
    parameter logic [3:0]  RESET_CODE     = 4'b1010
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] bcd4,
    output logic       frame_done
);

    localparam int DIV_W = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OVERSAMPLE_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic             armed;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       sub_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_err;
    logic             tick;

    logic [2:0][3:0]  slot;
    logic [1:0]       count;

    // Synchronizer clears to 0 so the line must be seen high before arming.
    always_ff @(posedge Clk) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_MAX);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            div_cnt   <= '0;
            sub_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err   <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            // Divider is held in IDLE so ticks are phase-aligned to the start edge.
            if (state == IDLE || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (!armed)
                        armed <= rx_s;
                    else if (!rx_s) begin
                        state   <= START;
                        sub_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sub_cnt == 4'd7) begin
                            sub_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sub_cnt <= sub_cnt + 1'b1;
                        if (sub_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        sub_cnt <= sub_cnt + 1'b1;
                        if (sub_cnt == 4'd15) begin
                            par_err <= (^shreg) ^ rx_s;
                            state   <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sub_cnt <= sub_cnt + 1'b1;
                        if (sub_cnt == 4'd15) begin
                            Rx_DATA   <= shreg;
                            Rx_VALID  <= ~par_err & rx_s;
                            Rx_PERROR <= par_err;
                            Rx_FERROR <= ~rx_s;
                            // A low stop bit may be a break: wait for the line to rise.
                            armed     <= rx_s;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit assembler: the fourth digit goes straight to bcd4.
    always_ff @(posedge Clk) begin
        if (reset) begin
            slot       <= '0;
            count      <= '0;
            bcd1       <= RESET_CODE;
            bcd2       <= RESET_CODE;
            bcd3       <= RESET_CODE;
            bcd4       <= RESET_CODE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (Rx_VALID) begin
                if (Rx_DATA[7:4] == 4'd0) begin
                    case (count)
                        2'd0: begin slot[0] <= Rx_DATA[3:0]; count <= 2'd1; end
                        2'd1: begin slot[1] <= Rx_DATA[3:0]; count <= 2'd2; end
                        2'd2: begin slot[2] <= Rx_DATA[3:0]; count <= 2'd3; end
                        default: begin
                            bcd1       <= slot[0];
                            bcd2       <= slot[1];
                            bcd3       <= slot[2];
                            bcd4       <= Rx_DATA[3:0];
                            frame_done <= 1'b1;
                            count      <= 2'd0;
                        end
                    endcase
                end else begin
                    count <= 2'd0;
                end
            end else if (Rx_PERROR || Rx_FERROR) begin
                count <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_digit_receiver.sv
// Directed bench: a UART model at 32 cycles/bit drives the receiver (OVERSAMPLE_DIV = 2).
module tb_uart_digit_receiver;

    localparam int BIT = 32;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR, frame_done;
    logic [3:0] bcd1, bcd2, bcd3, bcd4;

    uart_digit_receiver #(.OVERSAMPLE_DIV(2), .RESET_CODE(4'b1010)) dut (
        .Clk(Clk), .reset(reset), .RxD(RxD),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
        .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int v_cnt = 0, pe_cnt = 0, fe_cnt = 0, fd_cnt = 0, ov_cnt = 0, long_cnt = 0;
    int v0, pe0, fe0, fd0;
    logic v_prev = 1'b0;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge Clk) begin
        if (Rx_VALID)   v_cnt++;
        if (Rx_PERROR)  pe_cnt++;
        if (Rx_FERROR)  fe_cnt++;
        if (frame_done) fd_cnt++;
        if (Rx_VALID && (Rx_PERROR || Rx_FERROR)) ov_cnt++;
        if (Rx_VALID && v_prev) long_cnt++;
        v_prev = Rx_VALID;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        v0 = v_cnt; pe0 = pe_cnt; fe0 = fe_cnt; fd0 = fd_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_bit(input logic b);
        RxD = b;
        idle(BIT);
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ bad_par);
        drive_bit(stop);
    endtask

    task automatic send_ok(input logic [7:0] d);
        send(d, 1'b0, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"}, {24'd0, Rx_DATA}, 32'h0);
        chk({tag, "_flags"}, {28'd0, Rx_VALID, Rx_PERROR, Rx_FERROR, frame_done}, 32'h0);
        chk({tag, "_bcd"}, {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'hAAAA);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle(4);
        chk_reset_state("reset");
        reset = 1'b0;
        idle(2 * BIT);

        // Four good digits
        snap();
        send_ok(8'h0A); send_ok(8'h01); send_ok(8'h09); send_ok(8'h04);
        idle(4);
        chk("good_valid", v_cnt - v0, 4);
        chk("good_fd", fd_cnt - fd0, 1);
        chk("good_perr", pe_cnt - pe0, 0);
        chk("good_data", {24'd0, Rx_DATA}, 32'h04);
        chk("good_bcd", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'hA194);

        // Parity error mid-group
        snap();
        send_ok(8'h03); send_ok(8'h05); send(8'h07, 1'b1, 1'b1);
        idle(4);
        chk("par_perr", pe_cnt - pe0, 1);
        chk("par_valid", v_cnt - v0, 2);
        chk("par_data", {24'd0, Rx_DATA}, 32'h07);
        chk("par_bcd_hold", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'hA194);
        chk("par_fd_none", fd_cnt - fd0, 0);
        send_ok(8'h01); send_ok(8'h02); send_ok(8'h03); send_ok(8'h04);
        idle(4);
        chk("par_valid_all", v_cnt - v0, 6);
        chk("par_fd", fd_cnt - fd0, 1);
        chk("par_bcd", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'h1234);

        // Framing error followed by a 40-bit break
        snap();
        send(8'h06, 1'b0, 1'b0);
        idle(40 * BIT);
        chk("brk_ferr", fe_cnt - fe0, 1);
        chk("brk_valid", v_cnt - v0, 0);
        chk("brk_perr", pe_cnt - pe0, 0);
        chk("brk_data", {24'd0, Rx_DATA}, 32'h06);
        RxD = 1'b1;
        idle(2 * BIT);
        chk("brk_ferr_release", fe_cnt - fe0, 1);
        send_ok(8'h02);
        idle(4);
        chk("brk_next_valid", v_cnt - v0, 1);
        chk("brk_next_data", {24'd0, Rx_DATA}, 32'h02);

        // Glitch rejection
        snap();
        RxD = 1'b0;
        idle(6);
        RxD = 1'b1;
        idle(2 * BIT);
        chk("glitch_flags", (v_cnt - v0) + (pe_cnt - pe0) + (fe_cnt - fe0), 0);
        chk("glitch_data", {24'd0, Rx_DATA}, 32'h02);
        chk("glitch_bcd", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'h1234);

        // Resync byte clears a partial group
        snap();
        send_ok(8'h01); send_ok(8'hFF);
        send_ok(8'h08); send_ok(8'h08); send_ok(8'h08); send_ok(8'h08);
        idle(4);
        chk("resync_valid", v_cnt - v0, 6);
        chk("resync_fd", fd_cnt - fd0, 1);
        chk("resync_bcd", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'h8888);

        // Reset during the data bits of the third byte
        send_ok(8'h05); send_ok(8'h06);
        snap();
        fork
            send_ok(8'h07);
            begin
                idle(4 * BIT + 10);
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                chk_reset_state("midrst");
            end
        join
        idle(2 * BIT);
        chk("midrst_no_byte", v_cnt - v0, 0);
        snap();
        send_ok(8'h09); send_ok(8'h08); send_ok(8'h07); send_ok(8'h06);
        idle(4);
        chk("midrst_valid", v_cnt - v0, 4);
        chk("midrst_fd", fd_cnt - fd0, 1);
        chk("midrst_bcd", {16'd0, bcd1, bcd2, bcd3, bcd4}, 32'h9876);

        chk("valid_err_overlap", ov_cnt, 0);
        chk("valid_pulse_width", long_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
